// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: arbitrates the CPU fetch (m0), load (m1) and store (m2)
// Wishbone masters onto the single external Wishbone master port.
// One owner is latched per bus cycle and held until that owner drops cyc.
// Optional build macro: WB_ARB_TIMEOUT_EN adds a bus watchdog that aborts
// an OWNED cycle after TIMEOUT_CYCLES cycles without a slave response.
//
// Handshake: a master requests by raising i_mX_cyc and holds it for the
// whole bus cycle; it becomes owner one cycle later (o_grant bit set), the
// owner's cyc/stb/we/addr pass straight to the bus, slave ack/err go back to
// the owner only, and the owner releases by dropping cyc, after which the
// arbiter spends exactly one cycle in IDLE before any new grant.
module wb_master_arbiter #(
  parameter int ROUND_ROBIN    = 0,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_m0_cyc,
  input  logic          i_m1_cyc,
  input  logic          i_m2_cyc,
  input  logic [3:0]    i_m0_stb,
  input  logic [3:0]    i_m1_stb,
  input  logic [3:0]    i_m2_stb,
  input  logic          i_m0_we,
  input  logic          i_m1_we,
  input  logic          i_m2_we,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [AW-1:0] i_m2_addr,
  input  logic [DW-1:0] i_m2_dat,
  output logic          o_m0_ack,
  output logic          o_m1_ack,
  output logic          o_m2_ack,
  output logic          o_m0_err,
  output logic          o_m1_err,
  output logic          o_m2_err,
  output logic          o_wb_cyc,
  output logic [3:0]    o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_dat,
  input  logic          i_wb_ack,
  input  logic          i_wb_err,
  output logic [2:0]    o_grant,
  output logic          o_timeout,
  output logic          o_dbg_state
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_OWNED = 1'b1;

  logic       r_state;
  logic [2:0] r_grant;
  logic [1:0] r_ptr;

  logic [2:0] w_req;
  logic [2:0] w_win;
  logic [1:0] w_first;
  logic [1:0] w_next_ptr;
  logic       w_own_cyc;
  logic       w_timeout;

  assign w_req     = {i_m2_cyc, i_m1_cyc, i_m0_cyc};
  assign w_own_cyc = |(w_req & r_grant);

  // Winner selection: fixed m0>m1>m2, or search starting at r_ptr wrapping 2->0.
  always_comb begin
    w_win   = 3'b000;
    w_first = (ROUND_ROBIN != 0) ? r_ptr : 2'd0;
    case (w_first)
      2'd1: begin
        if (w_req[1])      w_win = 3'b010;
        else if (w_req[2]) w_win = 3'b100;
        else if (w_req[0]) w_win = 3'b001;
      end
      2'd2: begin
        if (w_req[2])      w_win = 3'b100;
        else if (w_req[0]) w_win = 3'b001;
        else if (w_req[1]) w_win = 3'b010;
      end
      default: begin
        if (w_req[0])      w_win = 3'b001;
        else if (w_req[1]) w_win = 3'b010;
        else if (w_req[2]) w_win = 3'b100;
      end
    endcase
  end

  // Pointer value after a release: the master following the current owner.
  always_comb begin
    w_next_ptr = 2'd0;
    case (r_grant)
      3'b001:  w_next_ptr = 2'd1;
      3'b010:  w_next_ptr = 2'd2;
      default: w_next_ptr = 2'd0;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] LP_TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_to_cnt;

  // Watchdog: counts OWNED cycles since grant or since the last slave response.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_to_cnt <= '0;
    end else if (r_state == ST_IDLE || i_wb_ack || i_wb_err) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == ST_OWNED) && (r_to_cnt == LP_TO_LAST);
`else
  localparam logic [31:0] LP_UNUSED_TO = TIMEOUT_CYCLES;
  logic w_unused_to;
  assign w_unused_to = ^LP_UNUSED_TO;
  assign w_timeout   = 1'b0;
`endif

  // Ownership FSM: latch a winner from IDLE, release on owner cyc drop or watchdog.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_grant <= 3'b000;
      r_ptr   <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_grant <= w_win;
            r_state <= ST_OWNED;
          end
        end
        default: begin
          if (!w_own_cyc || w_timeout) begin
            r_grant <= 3'b000;
            r_state <= ST_IDLE;
            r_ptr   <= w_next_ptr;
          end
        end
      endcase
    end
  end

  // Bus mux: owner's signals pass through combinationally; everything 0 in IDLE.
  always_comb begin
    o_wb_cyc  = 1'b0;
    o_wb_stb  = 4'b0000;
    o_wb_we   = 1'b0;
    o_wb_addr = '0;
    o_wb_dat  = '0;
    if (r_state == ST_OWNED) begin
      case (r_grant)
        3'b001: begin
          o_wb_cyc  = i_m0_cyc;
          o_wb_stb  = i_m0_stb;
          o_wb_we   = i_m0_we;
          o_wb_addr = i_m0_addr;
        end
        3'b010: begin
          o_wb_cyc  = i_m1_cyc;
          o_wb_stb  = i_m1_stb;
          o_wb_we   = i_m1_we;
          o_wb_addr = i_m1_addr;
        end
        3'b100: begin
          o_wb_cyc  = i_m2_cyc;
          o_wb_stb  = i_m2_stb;
          o_wb_we   = i_m2_we;
          o_wb_addr = i_m2_addr;
          o_wb_dat  = i_m2_dat;
        end
        default: begin
          o_wb_cyc = 1'b0;
        end
      endcase
    end
  end

  // Responses reach the owner only; grant is zero in IDLE so stray acks drop.
  assign o_m0_ack = i_wb_ack & r_grant[0];
  assign o_m1_ack = i_wb_ack & r_grant[1];
  assign o_m2_ack = i_wb_ack & r_grant[2];
  assign o_m0_err = (i_wb_err | w_timeout) & r_grant[0];
  assign o_m1_err = (i_wb_err | w_timeout) & r_grant[1];
  assign o_m2_err = (i_wb_err | w_timeout) & r_grant[2];

  assign o_grant     = r_grant;
  assign o_timeout   = w_timeout;
  assign o_dbg_state = r_state;

endmodule
